fifo_read_streamer: RTL and testbench
=====================================

# fifo_read_streamer

Read-side drain engine for the asynchronous FIFO, in the read clock domain. It issues pops against the FIFO read port (Pop/empty/registered DataOut) and presents each popped word on a downstream valid/ready stream. A small local buffer absorbs the FIFO's one-cycle read latency and downstream back-pressure without losing or duplicating words. It keeps a delivered-word counter for debug.

## Interface

Parameters:
- DataSize, 3: data word width; matches the FIFO DataSize.
- BufDepth, 3: local buffer entries; legal ≥2; ≥3 is required for one word per cycle.
- CountWidth, 8: width of DeliveredCount.

Ports:
- Rclk  in  1  single clock for the whole block (FIFO read clock).
- Rresetn  in  1  asynchronous, active-low reset.
- FifoEmpty  in  1  FIFO empty flag (registered in the FIFO).
- FifoDataOut  in  DataSize  FIFO DataOut; valid the cycle after a Pop is accepted.
- FifoPop  out  1  pop request to the FIFO.
- OutReady  in  1  downstream accepts a word.
- OutValid  out  1  OutData holds a valid word.
- OutData  out  DataSize  head of the local buffer.
- DeliveredCount  out  CountWidth  count of accepted words (OutValid && OutReady); wraps.

## Operation

- State: InFlight (1 bit) = FifoPop registered; Occ is 0..BufDepth; circular buffer with WrIdx/RdIdx. Each index wraps from BufDepth-1 to 0 by explicit compare, not by power-of-two truncation.
- FifoPop = !FifoEmpty && (Occ + InFlight < BufDepth). Combinational from FifoEmpty, Occ and InFlight only. It never depends on OutReady.
- Capture: when InFlight=1, write FifoDataOut into buffer[WrIdx] and advance WrIdx.
- Deliver: OutValid = (Occ != 0); OutData = buffer[RdIdx]. On OutValid && OutReady, advance RdIdx and increment DeliveredCount modulo 2^CountWidth.
- Occ update: +1 on capture, -1 on deliver, unchanged when both occur in the same cycle.
- Credit rule guarantees a capture never finds the buffer full. An overflow is a design error; the bench asserts it never happens.
- The block never pops while FifoEmpty=1, so no FIFO pop is wasted.
- OutValid/OutData hold stable until accepted (standard valid/ready). OutValid never drops without a handshake.

## Timing

- Reset (Rresetn low, asynchronous): Occ=0, InFlight=0, WrIdx=RdIdx=0, DeliveredCount=0, OutValid=0. FifoPop=0 because it is gated low while reset is asserted. Buffer contents are not reset. OutData is don't-care while OutValid=0.
- Latency: FifoPop high in cycle t → FifoDataOut valid in t+1, captured at the end of t+1 → OutValid=1 in cycle t+2.
- Throughput: with BufDepth ≥ 3, FifoEmpty=0 and OutReady=1, the block pops and delivers one word per cycle in steady state.
- Reset mid-operation: any in-flight word and all buffered words are discarded. The FIFO read side is reset by the same Rresetn, so the two stay consistent.
- Simultaneous capture and deliver with Occ=BufDepth is legal: Occ stays at BufDepth.
- Simultaneous capture and deliver with Occ=0 cannot occur. A captured word is visible only from the next cycle; there is no bypass.
- DeliveredCount wraps from 2^CountWidth-1 to 0 with no sticky flag.

## Structure

- Shared package: BufDepth default, index/occupancy width derivation (one function), and the DataSize default shared with the FIFO.
- One sub-module: read_skid_buffer. It contains the circular buffer, WrIdx/RdIdx, Occ, the capture/deliver ports and an Occ output.
- Top-level logic: the credit/pop logic, InFlight and DeliveredCount.

## Test plan

- Reset then FifoEmpty=1 for 20 cycles → FifoPop=0, OutValid=0, DeliveredCount=0 throughout.
- FIFO preloaded with 1,2,3,4,5; OutReady=1 → FifoPop high 5 consecutive cycles; OutData sequence 1,2,3,4,5 on consecutive cycles starting 2 cycles after the first pop; DeliveredCount=5.
- FIFO holds 8 words; OutReady=0 → exactly BufDepth (3) pops, then FifoPop=0 and OutValid=1 holding the first word. Raise OutReady → remaining words delivered in order with no gap or duplicate.
- Random OutReady (50%) with random FifoEmpty gaps over 1000 words → output order equals FIFO order; buffer never overflows; FifoPop never asserted while FifoEmpty=1.
- Assert Rresetn low for one cycle while Occ=2 and InFlight=1 → next cycle OutValid=0, Occ=0, FifoPop=0. Normal popping resumes when FifoEmpty=0.
- CountWidth=4; deliver 17 words → DeliveredCount reads 15 after word 15, 0 after word 16, 1 after word 17.

Source files
------------

// File: rtl/fifo_read_streamer_pkg.sv
// rtl/fifo_read_streamer_pkg.sv - shared defaults and width helper for the FIFO read streamer
package fifo_read_streamer_pkg;

    // Word width shared with the asynchronous FIFO.
    localparam int DATA_SIZE_DEFAULT = 3;
    // Three entries are the minimum for one word per cycle with a one-cycle read latency.
    localparam int BUF_DEPTH_DEFAULT = 3;

    // Bits needed to hold any value 0..max_val (at least one bit).
    // Used for both buffer indices (max BufDepth-1) and occupancy (max BufDepth).
    function automatic int bits_for(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/read_skid_buffer.sv
// rtl/read_skid_buffer.sv - circular buffer absorbing FIFO read latency and downstream stalls
// Ports:
//   Rclk, Rresetn : clock, asynchronous active-low reset
//   CapValid      : write CapData at the tail this cycle
//   CapData       : word returned by the FIFO
//   Deliver       : head word accepted downstream this cycle (only when Occ != 0)
//   HeadData      : word at the head of the buffer
//   Occ           : number of buffered words, 0..BufDepth
module read_skid_buffer
    import fifo_read_streamer_pkg::*;
#(
    parameter int DataSize = DATA_SIZE_DEFAULT,
    parameter int BufDepth = BUF_DEPTH_DEFAULT
) (
    input  logic                          Rclk,
    input  logic                          Rresetn,
    input  logic                          CapValid,
    input  logic [DataSize-1:0]           CapData,
    input  logic                          Deliver,
    output logic [DataSize-1:0]           HeadData,
    output logic [bits_for(BufDepth)-1:0] Occ
);

    localparam int IdxW = bits_for(BufDepth - 1);
    localparam int OccW = bits_for(BufDepth);
    localparam logic [IdxW-1:0] LAST_IDX = IdxW'(BufDepth - 1);

    logic [DataSize-1:0] mem_q [BufDepth];
    logic [IdxW-1:0]     wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]     rd_idx_q, rd_idx_d;
    logic [OccW-1:0]     occ_q, occ_d;

    // Indices wrap by explicit compare so non-power-of-two depths work.
    always_comb begin
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        occ_d    = occ_q;
        if (CapValid) begin
            wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IdxW'(1);
        end
        if (Deliver) begin
            rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IdxW'(1);
        end
        if (CapValid && !Deliver) begin
            occ_d = occ_q + OccW'(1);
        end else if (!CapValid && Deliver) begin
            occ_d = occ_q - OccW'(1);
        end
    end

    always_ff @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is not reset; Occ alone decides which entries are meaningful.
    always_ff @(posedge Rclk) begin
        if (CapValid) begin
            mem_q[wr_idx_q] <= CapData;
        end
    end

    assign HeadData = mem_q[rd_idx_q];
    assign Occ      = occ_q;

endmodule

// File: rtl/fifo_read_streamer.sv
// rtl/fifo_read_streamer.sv - drains the async FIFO read port onto a valid/ready stream
// Ports:
//   Rclk, Rresetn  : FIFO read clock, asynchronous active-low reset
//   FifoEmpty      : FIFO empty flag
//   FifoDataOut    : FIFO read data, valid the cycle after an accepted pop
//   FifoPop        : pop request to the FIFO
//   OutReady       : downstream accepts the presented word
//   OutValid       : OutData holds a valid word
//   OutData        : head of the local buffer
//   DeliveredCount : wrapping count of accepted words
module fifo_read_streamer
    import fifo_read_streamer_pkg::*;
#(
    parameter int DataSize   = DATA_SIZE_DEFAULT,
    parameter int BufDepth   = BUF_DEPTH_DEFAULT,
    parameter int CountWidth = 8
) (
    input  logic                  Rclk,
    input  logic                  Rresetn,
    input  logic                  FifoEmpty,
    input  logic [DataSize-1:0]   FifoDataOut,
    output logic                  FifoPop,
    input  logic                  OutReady,
    output logic                  OutValid,
    output logic [DataSize-1:0]   OutData,
    output logic [CountWidth-1:0] DeliveredCount
);

    localparam int OccW = bits_for(BufDepth);

    logic [OccW-1:0]       occ;
    logic [OccW:0]         credit_used;
    logic                  in_flight_q;
    logic                  deliver;
    logic [CountWidth-1:0] count_q, count_d;

    // A pop reserves a buffer slot for the word arriving next cycle, so the
    // buffer can never overflow. Downstream readiness deliberately plays no part.
    assign credit_used = {1'b0, occ} + {{OccW{1'b0}}, in_flight_q};
    assign FifoPop     = Rresetn && !FifoEmpty && (credit_used < (OccW + 1)'(BufDepth));

    assign OutValid = (occ != '0);
    assign deliver  = OutValid && OutReady;

    always_comb begin
        count_d = count_q;
        if (deliver) begin
            count_d = count_q + CountWidth'(1);
        end
    end

    always_ff @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            in_flight_q <= 1'b0;
            count_q     <= '0;
        end else begin
            in_flight_q <= FifoPop;
            count_q     <= count_d;
        end
    end

    assign DeliveredCount = count_q;

    read_skid_buffer #(
        .DataSize (DataSize),
        .BufDepth (BufDepth)
    ) u_buf (
        .Rclk     (Rclk),
        .Rresetn  (Rresetn),
        .CapValid (in_flight_q),
        .CapData  (FifoDataOut),
        .Deliver  (deliver),
        .HeadData (OutData),
        .Occ      (occ)
    );

endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb/tb_fifo_read_streamer.sv - directed and randomised bench for fifo_read_streamer
module tb_fifo_read_streamer;

    logic       Rclk = 1'b0;
    logic       Rresetn = 1'b1;
    logic       FifoEmpty;
    logic [2:0] FifoDataOut = 3'd0;
    logic       FifoPop;
    logic       OutReady = 1'b0;
    logic       OutValid;
    logic [2:0] OutData;
    logic [7:0] DeliveredCount;

    logic       FifoPop_b;
    logic       OutValid_b;
    logic [2:0] OutData_b;
    logic [3:0] DeliveredCount_b;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural FIFO read side: pointer pair plus a forced-empty gap control.
    logic [2:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       force_empty = 1'b0;

    assign FifoEmpty = (wr_ptr == rd_ptr) || force_empty;

    always #5 Rclk = ~Rclk;

    always @(posedge Rclk or negedge Rresetn) begin
        if (!Rresetn) begin
            rd_ptr <= 0;
        end else if (FifoPop) begin
            FifoDataOut <= mem[rd_ptr[9:0]];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    fifo_read_streamer #(.DataSize(3), .BufDepth(3), .CountWidth(8)) dut (
        .Rclk(Rclk), .Rresetn(Rresetn), .FifoEmpty(FifoEmpty), .FifoDataOut(FifoDataOut),
        .FifoPop(FifoPop), .OutReady(OutReady), .OutValid(OutValid), .OutData(OutData),
        .DeliveredCount(DeliveredCount)
    );

    fifo_read_streamer #(.DataSize(3), .BufDepth(3), .CountWidth(4)) dut_b (
        .Rclk(Rclk), .Rresetn(Rresetn), .FifoEmpty(FifoEmpty), .FifoDataOut(FifoDataOut),
        .FifoPop(FifoPop_b), .OutReady(OutReady), .OutValid(OutValid_b), .OutData(OutData_b),
        .DeliveredCount(DeliveredCount_b)
    );

    task automatic do_reset();
        @(negedge Rclk);
        Rresetn = 1'b0;
        wr_ptr = 0;
        force_empty = 1'b0;
        OutReady = 1'b0;
        @(negedge Rclk);
        Rresetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge Rclk);
        Rresetn = 1'b0;
        wr_ptr = 0;
        #1;
        tests_run++;
        if (OutValid !== 1'b0 || FifoPop !== 1'b0 || DeliveredCount !== 8'd0 || dut.u_buf.Occ !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state got valid=%b pop=%b cnt=%0d occ=%0d want 0 0 0 0",
                     OutValid, FifoPop, DeliveredCount, dut.u_buf.Occ);
        end
        @(negedge Rclk);
        Rresetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            tests_run++;
            if (FifoPop !== 1'b0 || OutValid !== 1'b0 || DeliveredCount !== 8'd0) begin
                tests_failed++;
                $display("FAIL idle_empty cycle %0d got pop=%b valid=%b cnt=%0d want 0 0 0",
                         c, FifoPop, OutValid, DeliveredCount);
            end
            @(negedge Rclk);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = 3'(i + 1);
        OutReady = 1'b1;
        wr_ptr = 5;
        for (int c = 0; c < 10; c++) begin
            #1;
            tests_run++;
            if (FifoPop !== 1'(c < 5)) begin
                tests_failed++;
                $display("FAIL stream_pop cycle %0d got %b want %b", c, FifoPop, 1'(c < 5));
            end
            tests_run++;
            if (OutValid !== 1'(c >= 2 && c < 7)) begin
                tests_failed++;
                $display("FAIL stream_valid cycle %0d got %b want %b", c, OutValid, 1'(c >= 2 && c < 7));
            end
            if (c >= 2 && c < 7) begin
                tests_run++;
                if (OutData !== 3'(c - 1)) begin
                    tests_failed++;
                    $display("FAIL stream_data cycle %0d got %0d want %0d", c, OutData, c - 1);
                end
            end
            @(negedge Rclk);
        end
        #1;
        tests_run++;
        if (DeliveredCount !== 8'd5) begin
            tests_failed++;
            $display("FAIL stream_count got %0d want 5", DeliveredCount);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] v [8];
        v = '{3'd3, 3'd6, 3'd1, 3'd4, 3'd7, 3'd2, 3'd5, 3'd0};
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = v[i];
        OutReady = 1'b0;
        wr_ptr = 8;
        for (int c = 0; c < 8; c++) begin
            #1;
            tests_run++;
            if (FifoPop !== 1'(c < 3)) begin
                tests_failed++;
                $display("FAIL bp_pop cycle %0d got %b want %b", c, FifoPop, 1'(c < 3));
            end
            tests_run++;
            if (OutValid !== 1'(c >= 2)) begin
                tests_failed++;
                $display("FAIL bp_valid cycle %0d got %b want %b", c, OutValid, 1'(c >= 2));
            end
            if (c >= 2) begin
                tests_run++;
                if (OutData !== 3'd3) begin
                    tests_failed++;
                    $display("FAIL bp_hold cycle %0d got %0d want 3", c, OutData);
                end
            end
            @(negedge Rclk);
        end
        #1;
        OutReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests_run++;
            if (OutValid !== 1'b1 || OutData !== v[k]) begin
                tests_failed++;
                $display("FAIL bp_drain word %0d got valid=%b data=%0d want 1 %0d", k, OutValid, OutData, v[k]);
            end
            @(negedge Rclk);
        end
        #1;
        tests_run++;
        if (OutValid !== 1'b0 || DeliveredCount !== 8'd8) begin
            tests_failed++;
            $display("FAIL bp_end got valid=%b cnt=%0d want 0 8", OutValid, DeliveredCount);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = 3'(i + 2);
        OutReady = 1'b0;
        wr_ptr = 5;
        repeat (3) @(negedge Rclk);
        #1;
        tests_run++;
        if (dut.u_buf.Occ !== 2'd2 || dut.in_flight_q !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre got occ=%0d inflight=%b want 2 1", dut.u_buf.Occ, dut.in_flight_q);
        end
        Rresetn = 1'b0;
        wr_ptr = 0;
        #1;
        tests_run++;
        if (OutValid !== 1'b0 || dut.u_buf.Occ !== 2'd0 || FifoPop !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset got valid=%b occ=%0d pop=%b want 0 0 0", OutValid, dut.u_buf.Occ, FifoPop);
        end
        @(negedge Rclk);
        Rresetn = 1'b1;
        mem[0] = 3'd4;
        mem[1] = 3'd3;
        wr_ptr = 2;
        OutReady = 1'b1;
        #1;
        tests_run++;
        if (FifoPop !== 1'b1 || OutValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_resume_pop got pop=%b valid=%b want 1 0", FifoPop, OutValid);
        end
        repeat (2) @(negedge Rclk);
        #1;
        tests_run++;
        if (OutValid !== 1'b1 || OutData !== 3'd4) begin
            tests_failed++;
            $display("FAIL mid_resume_data got valid=%b data=%0d want 1 4", OutValid, OutData);
        end
    endtask

    task automatic test_random();
        int hs;
        int cycles;
        do_reset();
        for (int i = 0; i < 1000; i++) mem[i] = 3'($urandom);
        wr_ptr = 1000;
        hs = 0;
        cycles = 0;
        while (hs < 1000 && cycles < 20000) begin
            force_empty = ($urandom_range(0, 3) == 0);
            OutReady = 1'($urandom_range(0, 1));
            #1;
            tests_run++;
            if (FifoPop && FifoEmpty) begin
                tests_failed++;
                $display("FAIL rnd_pop_empty cycle %0d got pop=1 want 0", cycles);
            end
            tests_run++;
            if (dut.u_buf.Occ > 2'd3 || (dut.u_buf.Occ == 2'd3 && dut.in_flight_q && !(OutValid && OutReady))) begin
                tests_failed++;
                $display("FAIL rnd_overflow cycle %0d got occ=%0d inflight=%b want no overflow",
                         cycles, dut.u_buf.Occ, dut.in_flight_q);
            end
            if (OutValid && OutReady) begin
                tests_run++;
                if (OutData !== mem[hs]) begin
                    tests_failed++;
                    $display("FAIL rnd_order word %0d got %0d want %0d", hs, OutData, mem[hs]);
                end
                hs++;
            end
            cycles++;
            @(negedge Rclk);
        end
        force_empty = 1'b0;
        OutReady = 1'b0;
        #1;
        tests_run++;
        if (hs != 1000) begin
            tests_failed++;
            $display("FAIL rnd_timeout got %0d words want 1000", hs);
        end
        tests_run++;
        if (DeliveredCount !== 8'd232 || DeliveredCount_b !== 4'd8) begin
            tests_failed++;
            $display("FAIL rnd_count got %0d/%0d want 232/8", DeliveredCount, DeliveredCount_b);
        end
    endtask

    task automatic test_count_wrap();
        int hs;
        do_reset();
        for (int i = 0; i < 17; i++) mem[i] = 3'(i);
        wr_ptr = 17;
        OutReady = 1'b1;
        hs = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            tests_run++;
            if (DeliveredCount_b !== 4'(hs % 16) || DeliveredCount !== 8'(hs)) begin
                tests_failed++;
                $display("FAIL wrap_count after %0d words got %0d/%0d want %0d/%0d",
                         hs, DeliveredCount_b, DeliveredCount, hs % 16, hs);
            end
            if (OutValid && OutReady) hs++;
            @(negedge Rclk);
        end
        #1;
        tests_run++;
        if (hs != 17 || DeliveredCount_b !== 4'd1) begin
            tests_failed++;
            $display("FAIL wrap_final got words=%0d cnt=%0d want 17 1", hs, DeliveredCount_b);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
